// File: rtl/load_unit.sv
// Memory-stage load unit: issues one bus read per load and returns the
// lane-extracted, sign/zero-extended 64-bit result.
package load_pkg;
    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2,
        MSIZE8 = 2'd3
    } msize_t;
endpackage

module load_unit
    import load_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [63:0] addr,
    input  msize_t      msize,
    input  logic        is_unsigned,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [63:0] rd,
    output logic        error,
    output logic        dreq_valid,
    output logic [63:0] dreq_addr,
    output msize_t      dreq_size,
    input  logic        dresp_addr_ok,
    input  logic        dresp_data_ok,
    input  logic [63:0] dresp_data
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [63:0] addr_q, addr_d;
    msize_t      size_q, size_d;
    logic        uns_q, uns_d;
    logic        flush_q, flush_d;
    logic [63:0] rd_q, rd_d;
    logic        err_q, err_d;

    logic        misaligned;
    logic [63:0] shifted;
    logic [63:0] extended;

    // Address acceptance carries no information the data phase needs.
    logic unused_addr_ok;
    assign unused_addr_ok = dresp_addr_ok;

    always_comb begin
        misaligned = 1'b0;
        unique case (msize)
            MSIZE1: misaligned = 1'b0;
            MSIZE2: misaligned = addr[0];
            MSIZE4: misaligned = |addr[1:0];
            MSIZE8: misaligned = |addr[2:0];
            default: misaligned = 1'b0;
        endcase
    end

    // Doubleword loads are always aligned here, so the shift is zero.
    assign shifted = dresp_data >> {addr_q[2:0], 3'b000};

    always_comb begin
        extended = shifted;
        unique case (size_q)
            MSIZE1: extended = uns_q ? {56'd0, shifted[7:0]}
                                     : {{56{shifted[7]}}, shifted[7:0]};
            MSIZE2: extended = uns_q ? {48'd0, shifted[15:0]}
                                     : {{48{shifted[15]}}, shifted[15:0]};
            MSIZE4: extended = uns_q ? {32'd0, shifted[31:0]}
                                     : {{32{shifted[31]}}, shifted[31:0]};
            MSIZE8: extended = shifted;
            default: extended = shifted;
        endcase
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        size_d  = size_q;
        uns_d   = uns_q;
        flush_d = flush_q;
        rd_d    = rd_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d  = addr;
                    size_d  = msize;
                    uns_d   = is_unsigned;
                    flush_d = 1'b0;
                    rd_d    = 64'd0;
                    err_d   = misaligned;
                    state_d = misaligned ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (flush) begin
                    flush_d = 1'b1;
                end
                if (dresp_data_ok) begin
                    flush_d = 1'b0;
                    if (flush_q || flush) begin
                        state_d = S_IDLE;
                    end else begin
                        rd_d    = extended;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= 64'd0;
            size_q  <= MSIZE1;
            uns_q   <= 1'b0;
            flush_q <= 1'b0;
            rd_q    <= 64'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            flush_q <= flush_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
        end
    end

    logic in_done;
    assign in_done    = (state_q == S_DONE);
    assign busy       = (state_q != S_IDLE);
    assign done       = in_done && !flush;
    assign rd         = in_done ? rd_q : 64'd0;
    assign error      = in_done && err_q;
    assign dreq_valid = (state_q == S_WAIT);
    assign dreq_addr  = addr_q;
    assign dreq_size  = size_q;

endmodule

// File: tb/tb_load_unit.sv
// Bench for load_unit: directed vector table, random loads against a
// byte-level reference model, and flush/reset/DONE corner sequences.
module tb_load_unit;
    import load_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [63:0] addr;
    msize_t      msize;
    logic        is_unsigned;
    logic        flush;
    logic        busy;
    logic        done;
    logic [63:0] rd;
    logic        error;
    logic        dreq_valid;
    logic [63:0] dreq_addr;
    msize_t      dreq_size;
    logic        dresp_addr_ok;
    logic        dresp_data_ok;
    logic [63:0] dresp_data;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    load_unit dut (
        .clk(clk), .reset(reset), .start(start), .addr(addr),
        .msize(msize), .is_unsigned(is_unsigned), .flush(flush),
        .busy(busy), .done(done), .rd(rd), .error(error),
        .dreq_valid(dreq_valid), .dreq_addr(dreq_addr),
        .dreq_size(dreq_size), .dresp_addr_ok(dresp_addr_ok),
        .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data)
    );

    typedef struct {
        string       name;
        logic [63:0] a;
        msize_t      sz;
        logic        uns;
        logic [63:0] data;
        int          lat;
        logic [63:0] exp_rd;
        logic        exp_err;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: little-endian byte pick, then mask and extend arithmetically.
    function automatic logic [64:0] model(input logic [63:0] a,
                                          input int nbytes,
                                          input bit uns,
                                          input logic [63:0] d);
        logic [63:0] v;
        logic [63:0] mask;
        int off;
        if ((a % nbytes) != 0) return {1'b1, 64'd0};
        off = int'(a % 8);
        v = d >> (off * 8);
        if (nbytes == 8) return {1'b0, d};
        mask = (64'd1 << (nbytes * 8)) - 64'd1;
        v = v & mask;
        if (!uns && v[nbytes * 8 - 1]) v = v | ~mask;
        return {1'b0, v};
    endfunction

    task automatic run_load(input vec_t v);
        int vcnt;
        start = 1'b1;
        addr = v.a;
        msize = v.sz;
        is_unsigned = v.uns;
        step();
        start = 1'b0;
        addr = {$urandom, $urandom};
        if (v.exp_err) begin
            chk({v.name, ".done"}, done, 1);
            chk({v.name, ".err"}, error, 1);
            chk({v.name, ".rd"}, rd, 0);
            chk({v.name, ".dreq"}, dreq_valid, 0);
            step();
            chk({v.name, ".idle"}, {busy, done, dreq_valid}, 0);
            return;
        end
        vcnt = 0;
        for (int i = 0; i <= v.lat; i++) begin
            if (dreq_valid) vcnt++;
            if (dreq_addr !== v.a || dreq_size !== v.sz || done)
                chk({v.name, ".req"}, {dreq_addr, 6'd0, dreq_size, done},
                    {v.a, 6'd0, v.sz, 1'b0});
            dresp_addr_ok = (i == 0);
            dresp_data_ok = (i == v.lat);
            dresp_data = (i == v.lat) ? v.data : {$urandom, $urandom};
            step();
        end
        dresp_addr_ok = 1'b0;
        dresp_data_ok = 1'b0;
        dresp_data = {$urandom, $urandom};
        chk({v.name, ".vcnt"}, vcnt, v.lat + 1);
        chk({v.name, ".done"}, {done, error, dreq_valid}, 3'b100);
        chk({v.name, ".rd"}, rd, v.exp_rd);
        step();
        chk({v.name, ".after"}, {busy, done}, 0);
    endtask

    vec_t tbl[$];
    vec_t rv;
    logic [64:0] m;

    initial begin
        reset = 1'b1;
        start = 1'b0;
        addr = '0;
        msize = MSIZE1;
        is_unsigned = 1'b0;
        flush = 1'b0;
        dresp_addr_ok = 1'b0;
        dresp_data_ok = 1'b0;
        dresp_data = '0;

        tbl.push_back('{"lb_1003", 64'h1003, MSIZE1, 1'b0,
            64'h1122334455667788, 2, 64'h55, 1'b0});
        tbl.push_back('{"lb_s", 64'h1000, MSIZE1, 1'b0,
            64'h1122334455667788, 0, 64'hFFFFFFFFFFFFFF88, 1'b0});
        tbl.push_back('{"lbu", 64'h1000, MSIZE1, 1'b1,
            64'h1122334455667788, 1, 64'h88, 1'b0});
        tbl.push_back('{"lh", 64'h1006, MSIZE2, 1'b0,
            64'h1122334455667788, 0, 64'h1122, 1'b0});
        tbl.push_back('{"lw_s", 64'h2004, MSIZE4, 1'b0,
            64'h8000000000000000, 3, 64'hFFFFFFFF80000000, 1'b0});
        tbl.push_back('{"lwu", 64'h2004, MSIZE4, 1'b1,
            64'h8000000000000000, 1, 64'h80000000, 1'b0});
        tbl.push_back('{"ld", 64'h2008, MSIZE8, 1'b0,
            64'hFEDCBA9876543210, 1, 64'hFEDCBA9876543210, 1'b0});
        tbl.push_back('{"lw_mis", 64'h1002, MSIZE4, 1'b0,
            64'h0, 0, 64'h0, 1'b1});
        tbl.push_back('{"ld_mis", 64'h100C, MSIZE8, 1'b0,
            64'h0, 0, 64'h0, 1'b1});
        tbl.push_back('{"lh_mis", 64'h1007, MSIZE2, 1'b1,
            64'h0, 0, 64'h0, 1'b1});

        step();
        step();
        chk("rst_out", {busy, done, error, dreq_valid}, 0);
        chk("rst_rd", rd, 0);
        chk("rst_addr", dreq_addr, 0);
        reset = 1'b0;
        step();

        foreach (tbl[i]) run_load(tbl[i]);

        for (int n = 0; n < 60; n++) begin
            int sz;
            int nb;
            sz = $urandom_range(0, 3);
            nb = 1 << sz;
            rv.name = $sformatf("rnd%0d", n);
            rv.a = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0)
                rv.a = rv.a & ~(64'(nb) - 64'd1);
            rv.sz = msize_t'(sz);
            rv.uns = 1'($urandom_range(0, 1));
            rv.data = {$urandom, $urandom};
            rv.lat = $urandom_range(0, 4);
            m = model(rv.a, nb, rv.uns, rv.data);
            rv.exp_err = m[64];
            rv.exp_rd = m[63:0];
            run_load(rv);
        end

        // flush one cycle into WAIT, data three cycles later
        start = 1'b1; addr = 64'h3000; msize = MSIZE8;
        step();
        start = 1'b0;
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_hold1", dreq_valid, 1);
        step();
        chk("fl_hold2", {dreq_valid, done}, 2'b10);
        step();
        dresp_data_ok = 1'b1;
        dresp_data = 64'h1234;
        chk("fl_hold3", {dreq_valid, busy}, 2'b11);
        step();
        dresp_data_ok = 1'b0;
        chk("fl_end", {busy, done, dreq_valid}, 0);
        step();
        chk("fl_nodone", done, 0);
        rv = '{"post_fl", 64'h3002, MSIZE2, 1'b1,
               64'h0000_0000_ABCD_0000, 1, 64'hABCD, 1'b0};
        run_load(rv);

        // flush on the same cycle as data_ok still kills the result
        start = 1'b1; addr = 64'h40; msize = MSIZE4;
        step();
        start = 1'b0;
        flush = 1'b1;
        dresp_data_ok = 1'b1;
        step();
        flush = 1'b0;
        dresp_data_ok = 1'b0;
        chk("fl_same", {busy, done}, 0);

        // reset during WAIT, then a stale response
        start = 1'b1; addr = 64'h5000; msize = MSIZE8;
        step();
        start = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rw_out", {dreq_valid, busy, done}, 0);
        dresp_data_ok = 1'b1;
        dresp_data = 64'hDEAD;
        step();
        dresp_data_ok = 1'b0;
        chk("rw_stale", {done, busy}, 0);
        step();
        chk("rw_stale2", {done, busy}, 0);

        // start while in DONE is ignored
        start = 1'b1; addr = 64'h1001; msize = MSIZE2;
        step();
        addr = 64'h1000; msize = MSIZE1;
        chk("dn_done", {done, error}, 2'b11);
        step();
        start = 1'b0;
        chk("dn_ign", {busy, dreq_valid, done}, 0);

        // flush in DONE suppresses the pulse
        start = 1'b1; addr = 64'h1003; msize = MSIZE4;
        step();
        start = 1'b0;
        flush = 1'b1;
        #1;
        chk("dn_flush", done, 0);
        flush = 1'b0;
        step();
        chk("dn_fl_end", {busy, done}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
